line_window_gen: RTL and testbench
==================================

// Module: line_window_gen
// PURPOSE
//  Streaming 3x3 neighbourhood generator for the image-processing path. Accepts one
//  raster-order pixel per handshake, holds two previous lines in internal line buffers,
//  and emits every full (interior) 3x3 window with a valid/ready handshake.
//  It replaces the fixed BRAM-column/mux scheme with a parametrised, backpressured stage
//  that feeds the kernel (filter) blocks.
// PARAMETERS
//  PIX_W   8  bits per pixel
//  IMG_W   8  pixels per line (>=3)
//  IMG_H   8  lines per frame (>=3)
// PORTS
//  clk        in   1          single clock; all logic rising-edge
//  RESET      in   1          synchronous, active-low reset
//  start      in   1          begin a frame (sampled in IDLE or DONE only)
//  pix_in     in   PIX_W      input pixel, raster order
//  pix_valid  in   1          pix_in valid
//  pix_ready  out  1          block accepts pix_in this cycle
//  win_out    out  9*PIX_W    window; out1 (top-left) at [PIX_W-1:0] ... out9 (bottom-right) at MSBs
//  win_valid  out  1          win_out valid
//  win_ready  in   1          downstream accepts window
//  complete   out  1          frame finished (level)
// BEHAVIOUR
//  - Reset (RESET==0 at clk edge): state=IDLE, col=row=0, pix_ready=0, win_valid=0,
//    win_out=0, complete=0. Line-buffer contents not cleared (gated by counters).
//    Reset mid-frame aborts the frame; no window emitted after it until next start.
//  - FSM: IDLE -start-> RUN; RUN -last pixel (row=IMG_H-1,col=IMG_W-1) accepted-> DRAIN;
//    DRAIN -final window accepted-> DONE; DONE -start-> RUN. start in RUN/DRAIN ignored.
//    Entering RUN clears col,row,complete.
//  - pix_ready = (state==RUN) && (!win_valid || win_ready). Pixel accepted on
//    pix_valid && pix_ready. Unaccepted pixels: no state change.
//  - On accept: col increments, wraps IMG_W-1 -> 0 with row+1; line buffers shift
//    (lb1[col] <= pix_in, lb2[col] <= old lb1[col]); 3x3 shift registers shift left one column
//    taking {lb2[col], lb1[col], pix_in} as the new right column.
//  - Window emission: accept of pixel (r,c) with r>=2 and c>=2 loads win_out next cycle
//    with rows r-2..r, cols c-2..c; win_valid=1. Latency 1 cycle. Windows straddling a
//    line wrap (c<2) are never emitted. Count per frame = (IMG_W-2)*(IMG_H-2).
//  - win_valid holds with win_out stable until win_valid&&win_ready; clears that cycle
//    unless a new window is loaded in the same cycle (pass-through, full throughput).
//  - complete=1 from DRAIN->DONE transition until next start or reset.
//  - Counters sized $clog2(IMG_W), $clog2(IMG_H); no arithmetic on pixel data.
// TESTING
//  1 8x8 ramp pix=r*8+c, win_ready=1: 36 windows; first = {0,1,2,8,9,10,16,17,18},
//    last = {45,46,47,53,54,55,61,62,63}; complete=1 one cycle after last window accepted.
//  2 win_ready=0 for 5 cycles at window 3: win_out stable, pix_ready=0, no pixel lost;
//    resume -> window sequence identical to scenario 1.
//  3 pix_valid random 50%: same 36 windows in same order as scenario 1.
//  4 start pulse mid-frame (row 4): ignored; frame completes normally, 36 windows.
//  5 RESET low at row 3 col 5: outputs to reset values next edge; new start + full frame
//    -> exactly 36 correct windows, none from aborted frame.
//  6 IMG_W=16, IMG_H=4, ramp r*16+c: 28 windows; first = {0,1,2,16,17,18,32,33,34}.

Source files
------------

// File: rtl/line_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 column shift
// register, emitting interior windows only, with valid/ready on both sides.
module line_window_gen #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               start,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [9*PIX_W-1:0] win_out,
  output logic               win_valid,
  input  logic               win_ready,
  output logic               complete
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_reg, state_next;

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;

  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];

  // Per window row (0=top .. 2=bottom): sh0 holds column c-2, sh1 column c-1.
  logic [PIX_W-1:0] sh0_reg [3];
  logic [PIX_W-1:0] sh1_reg [3];
  logic [PIX_W-1:0] new_col [3];

  logic [9*PIX_W-1:0] win_next;
  logic [9*PIX_W-1:0] win_out_reg;
  logic               win_valid_reg;
  logic               complete_reg;

  logic pix_acc, win_acc, last_pix, emit, restart;

  assign pix_acc  = pix_valid && pix_ready;
  assign win_acc  = win_valid_reg && win_ready;
  assign last_pix = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
  assign emit     = pix_acc && (row_reg >= RW'(2)) && (col_reg >= CW'(2));
  assign restart  = start && ((state_reg == IDLE) || (state_reg == DONE));

  assign new_col[0] = lb2[col_reg];
  assign new_col[1] = lb1[col_reg];
  assign new_col[2] = pix_in;

  // State register
  always_ff @(posedge clk) begin
    if (!RESET) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (pix_acc && last_pix) state_next = DRAIN;
      DRAIN:   if (win_acc) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: a pixel may enter only if its window slot is free or draining now.
  always_comb begin
    pix_ready = (state_reg == RUN) && (!win_valid_reg || win_ready);
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (restart) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (pix_acc) begin
      if (col_reg == COL_LAST) begin
        col_reg <= '0;
        row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + RW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

  // Line buffers are not reset: rows 0..1 of a new frame overwrite them before use.
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      lb1[col_reg] <= pix_in;
      lb2[col_reg] <= lb1[col_reg];
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      always_ff @(posedge clk) begin
        if (pix_acc) begin
          sh0_reg[gi] <= sh1_reg[gi];
          sh1_reg[gi] <= new_col[gi];
        end
      end
      assign win_next[(3*gi+0)*PIX_W +: PIX_W] = sh0_reg[gi];
      assign win_next[(3*gi+1)*PIX_W +: PIX_W] = sh1_reg[gi];
      assign win_next[(3*gi+2)*PIX_W +: PIX_W] = new_col[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!RESET) begin
      win_out_reg   <= '0;
      win_valid_reg <= 1'b0;
      complete_reg  <= 1'b0;
    end else begin
      if (emit) begin
        win_out_reg   <= win_next;
        win_valid_reg <= 1'b1;
      end else if (win_acc) begin
        win_valid_reg <= 1'b0;
      end
      complete_reg <= (state_next == DONE);
    end
  end

  assign win_out   = win_out_reg;
  assign win_valid = win_valid_reg;
  assign complete  = complete_reg;

endmodule

// File: tb/tb_line_window_gen.sv
// Scoreboard bench for line_window_gen: an 8x8 instance and a 16x4 instance
// share stimulus; sel chooses which one is driven and observed.
module tb_line_window_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        win_ready = 1'b1;
  logic        sel = 1'b0;

  logic        pr_a, wv_a, cp_a, pr_b, wv_b, cp_b;
  logic [71:0] wo_a, wo_b;
  logic        pix_ready, win_valid, complete;
  logic [71:0] win_out;

  logic [71:0] sb [$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  line_window_gen #(.PIX_W(8), .IMG_W(8), .IMG_H(8)) dut_a (
    .clk(clk), .RESET(rst_n), .start(start && !sel), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pr_a), .win_out(wo_a), .win_valid(wv_a),
    .win_ready(win_ready), .complete(cp_a)
  );

  line_window_gen #(.PIX_W(8), .IMG_W(16), .IMG_H(4)) dut_b (
    .clk(clk), .RESET(rst_n), .start(start && sel), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pr_b), .win_out(wo_b), .win_valid(wv_b),
    .win_ready(win_ready), .complete(cp_b)
  );

  assign pix_ready = sel ? pr_b : pr_a;
  assign win_valid = sel ? wv_b : wv_a;
  assign win_out   = sel ? wo_b : wo_a;
  assign complete  = sel ? cp_b : cp_a;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp_v);
    end
  endtask

  // Runs one frame from a start pulse. Optional: stall at a window index,
  // a stray start at a row, or an abort by reset just before pixel (abort_r, abort_c).
  task automatic run_frame(input int w, input int h, input int vprob, input int rprob,
                           input int stall_win, input int start_row,
                           input int abort_r, input int abort_c, input bit rnd_data,
                           output logic [71:0] first_w, output logic [71:0] last_w);
    logic [7:0]  img [256];
    logic [71:0] held, exp_v;
    int total_pix, exp_wins, p, wins, stall_left, r, c;
    bit stalled_done, start_done, aborted;
    total_pix = w * h;
    exp_wins  = (w - 2) * (h - 2);
    for (int i = 0; i < total_pix; i++) img[i] = rnd_data ? 8'($urandom) : 8'(i);
    first_w = '0;
    last_w  = '0;
    held    = '0;
    sb.delete();

    @(negedge clk);
    start = 1'b1; pix_valid = 1'b0; win_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("complete_cleared", 72'(complete), 72'd0);
    check_val("ready_in_run", 72'(pix_ready), 72'd1);

    p = 0; wins = 0; stall_left = 0;
    stalled_done = 0; start_done = 0; aborted = 0;
    for (int cyc = 0; cyc < 3000 && wins < exp_wins && !aborted; cyc++) begin
      pix_valid = (p < total_pix) && ($urandom_range(99) < vprob);
      pix_in    = (p < total_pix) ? img[p] : 8'h00;
      if (stall_left == 0 && !stalled_done && stall_win >= 0 && wins == stall_win && win_valid) begin
        stall_left = 5; held = win_out; stalled_done = 1;
      end
      win_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rprob);
      start = (start_row >= 0 && !start_done && (p / w) == start_row);
      if (start) start_done = 1;
      if (abort_r >= 0 && p == abort_r * w + abort_c) begin
        aborted = 1; rst_n = 1'b0;
      end
      #1;
      if (!aborted) begin
        if (stall_left > 0) begin
          check_val("stall_hold", win_out, held);
          check_val("stall_pix_ready", 72'(pix_ready), 72'd0);
          stall_left--;
        end
        if (win_valid && win_ready) begin
          check_val("sb_nonempty", 72'(sb.size() != 0), 72'd1);
          exp_v = (sb.size() != 0) ? sb.pop_front() : '0;
          check_val("window", win_out, exp_v);
          $display("win %0d: %h", wins, win_out);
          if (wins == 0) first_w = win_out;
          wins++;
          if (wins == exp_wins) begin
            last_w = win_out;
            check_val("complete_early", 72'(complete), 72'd0);
          end
        end
        if (pix_valid && pix_ready) begin
          r = p / w; c = p % w;
          if (r >= 2 && c >= 2) begin
            exp_v = '0;
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                exp_v[(i*3+j)*8 +: 8] = img[(r-2+i)*w + (c-2+j)];
            sb.push_back(exp_v);
          end
          p++;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b1;

    if (aborted) begin
      check_val("abort_win_valid", 72'(win_valid), 72'd0);
      check_val("abort_win_out", win_out, 72'd0);
      check_val("abort_pix_ready", 72'(pix_ready), 72'd0);
      check_val("abort_complete", 72'(complete), 72'd0);
      rst_n = 1'b1;
      pix_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check_val("post_abort_quiet", 72'({win_valid, pix_ready}), 72'd0);
      end
      pix_valid = 1'b0;
      sb.delete();
    end else begin
      check_val("window_count", 72'(wins), 72'(exp_wins));
      check_val("sb_drained", 72'(sb.size()), 72'd0);
      check_val("complete_set", 72'(complete), 72'd1);
      check_val("end_win_valid", 72'(win_valid), 72'd0);
      check_val("end_pix_ready", 72'(pix_ready), 72'd0);
      $display("frame %0dx%0d: %0d windows", w, h, wins);
    end
  endtask

  initial begin
    logic [71:0] fw, lw;
    repeat (3) @(negedge clk);
    check_val("rst_pix_ready", 72'(pix_ready), 72'd0);
    check_val("rst_win_valid", 72'(win_valid), 72'd0);
    check_val("rst_win_out", win_out, 72'd0);
    check_val("rst_complete", 72'(complete), 72'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_pix_ready", 72'(pix_ready), 72'd0);

    // Plain ramp, full throughput
    run_frame(8, 8, 100, 100, -1, -1, -1, 0, 1'b0, fw, lw);
    check_val("first_8x8", fw, {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0});
    check_val("last_8x8", lw, {8'd63, 8'd62, 8'd61, 8'd55, 8'd54, 8'd53, 8'd47, 8'd46, 8'd45});
    // Backpressure at window 3
    run_frame(8, 8, 100, 100, 3, -1, -1, 0, 1'b0, fw, lw);
    // Sparse input
    run_frame(8, 8, 50, 100, -1, -1, -1, 0, 1'b0, fw, lw);
    // Stray start in row 4
    run_frame(8, 8, 100, 100, -1, 4, -1, 0, 1'b0, fw, lw);
    // Abort at row 3 col 5, then a clean frame
    run_frame(8, 8, 100, 100, -1, -1, 3, 5, 1'b0, fw, lw);
    run_frame(8, 8, 100, 100, -1, -1, -1, 0, 1'b0, fw, lw);
    check_val("first_after_abort", fw, {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0});
    // Random data with random handshakes on both sides
    run_frame(8, 8, 70, 60, -1, -1, -1, 0, 1'b1, fw, lw);
    // Wide, short image
    sel = 1'b1;
    run_frame(16, 4, 100, 100, -1, -1, -1, 0, 1'b0, fw, lw);
    check_val("first_16x4", fw, {8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16, 8'd2, 8'd1, 8'd0});
    check_val("last_16x4", lw, {8'd63, 8'd62, 8'd61, 8'd47, 8'd46, 8'd45, 8'd31, 8'd30, 8'd29});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
